// File: rtl/updown_counter_sequencer_if.sv
// Command channel of the up/down counter sequencer: valid/ready handshake
// carrying the mode, bounds, pass count and an abort strobe.
interface updown_counter_sequencer_if #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [WIDTH-1:0]  cmd_lo;
    logic [WIDTH-1:0]  cmd_hi;
    logic [PASS_W-1:0] cmd_passes;
    logic              cmd_abort;

    modport master (
        output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_passes, cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_passes, cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/updown_counter_sequencer.sv
// Sequences a WIDTH-bit up/down counter through UP, DOWN, BOUNCE and CLEAR commands.
// Optional feature macro CNT_SEQ_TRACK_CHECK_EN adds an expected-count tracker that aborts on divergence.
module updown_counter_sequencer #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    updown_counter_sequencer_if.slave    cmd_bus,
    input  logic [WIDTH-1:0]             cnt_count,
    output logic                         cnt_rst,
    output logic                         cnt_up_down,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    state_t            state, state_next;
    logic [1:0]        mode_q;
    logic [WIDTH-1:0]  lo_q, hi_q;
    logic [PASS_W-1:0] last_pass_q, pass_cnt;
    logic              stepped, hi_seen, dir;
    logic              accept, arrival, final_arr, err_next, mismatch;

`ifdef CNT_SEQ_TRACK_CHECK_EN
    logic [WIDTH-1:0]  expect_q;

    assign mismatch = (state == RUN) && (cnt_count != expect_q);

    always_ff @(posedge clk) begin
        if (rst || state != RUN)
            expect_q <= '0;
        else if (cnt_up_down)
            expect_q <= expect_q + WIDTH'(1);
        else
            expect_q <= expect_q - WIDTH'(1);
    end
`else
    assign mismatch = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next        = state;
        cmd_bus.cmd_ready = 1'b0;
        cnt_rst           = 1'b1;
        cnt_up_down       = 1'b1;
        accept            = 1'b0;
        arrival           = 1'b0;
        final_arr         = 1'b0;
        err_next          = 1'b0;
        case (state)
            IDLE: begin
                cmd_bus.cmd_ready = 1'b1;
                accept            = cmd_bus.cmd_valid;
                if (accept) begin
                    if (cmd_bus.cmd_mode == MODE_CLEAR)
                        state_next = DONE;
                    else if (cmd_bus.cmd_mode == MODE_BOUNCE && cmd_bus.cmd_lo >= cmd_bus.cmd_hi)
                        err_next = 1'b1;
                    else
                        state_next = RUN;
                end
            end
            RUN: begin
                cnt_rst = 1'b0;
                case (mode_q)
                    MODE_UP: begin
                        cnt_up_down = 1'b1;
                        arrival     = stepped && (cnt_count == hi_q);
                    end
                    MODE_DOWN: begin
                        cnt_up_down = 1'b0;
                        arrival     = stepped && (cnt_count == lo_q);
                    end
                    default: begin
                        // Turn around in the very cycle a bound is seen so the counter never overshoots
                        if (cnt_count == hi_q)
                            cnt_up_down = 1'b0;
                        else if (cnt_count == lo_q)
                            cnt_up_down = 1'b1;
                        else
                            cnt_up_down = dir;
                        arrival = stepped && ((cnt_count == hi_q) || (hi_seen && cnt_count == lo_q));
                    end
                endcase
                final_arr = arrival && (pass_cnt == last_pass_q);
                if (cmd_bus.cmd_abort || mismatch) begin
                    cnt_rst    = 1'b1;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (final_arr) begin
                    cnt_rst    = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            cmd_bus.cmd_ready = 1'b0;
            cnt_rst           = 1'b1;
            cnt_up_down       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err         <= 1'b0;
            pass_cnt    <= '0;
            stepped     <= 1'b0;
            hi_seen     <= 1'b0;
            dir         <= 1'b1;
            mode_q      <= MODE_UP;
            lo_q        <= '0;
            hi_q        <= '0;
            last_pass_q <= '0;
        end else begin
            state   <= state_next;
            err     <= err_next;
            stepped <= (state == RUN);
            if (accept) begin
                mode_q      <= cmd_bus.cmd_mode;
                lo_q        <= cmd_bus.cmd_lo;
                hi_q        <= cmd_bus.cmd_hi;
                // A pass count of zero behaves as a single pass
                last_pass_q <= (cmd_bus.cmd_passes == '0) ? '0 : cmd_bus.cmd_passes - PASS_W'(1);
            end
            if (state != RUN) begin
                pass_cnt <= '0;
                hi_seen  <= 1'b0;
                dir      <= 1'b1;
            end else begin
                dir <= cnt_up_down;
                if (arrival)
                    pass_cnt <= pass_cnt + PASS_W'(1);
                if (arrival && cnt_count == hi_q)
                    hi_seen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Self-checking bench: directed and random commands against a closed-form trajectory model.
module tb_updown_counter_sequencer;
    localparam int WIDTH  = 3;
    localparam int PASS_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cnt_model;
    logic [WIDTH-1:0] cnt_count;
    logic             glitch_en = 1'b0;
    logic [WIDTH-1:0] glitch_val = '0;
    logic             cnt_rst, cnt_up_down, busy, done, err;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    updown_counter_sequencer_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

    updown_counter_sequencer #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_bus     (bus),
        .cnt_count   (cnt_count),
        .cnt_rst     (cnt_rst),
        .cnt_up_down (cnt_up_down),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Behavioural 3-bit up/down counter driven by the sequencer
    always @(posedge clk) begin
        if (cnt_rst)
            cnt_model <= '0;
        else if (cnt_up_down)
            cnt_model <= cnt_model + 3'd1;
        else
            cnt_model <= cnt_model - 3'd1;
    end

    assign cnt_count = glitch_en ? glitch_val : cnt_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Number of RUN cycles after the first one until the final arrival
    function automatic int ref_len(input int mode, input int lo, input int hi, input int p);
        int eff;
        int s;
        eff = (p == 0) ? 1 : p;
        if (mode == 0) begin
            s = (hi == 0) ? 8 : hi;
            return s + 8 * (eff - 1);
        end else if (mode == 1) begin
            s = (8 - lo) % 8;
            if (s == 0) s = 8;
            return s + 8 * (eff - 1);
        end
        return hi + (eff - 1) * (hi - lo);
    endfunction

    function automatic int ref_val(input int mode, input int lo, input int hi, input int k);
        int d;
        int m;
        if (mode == 0) return k % 8;
        if (mode == 1) return (8 - (k % 8)) % 8;
        if (k <= hi) return k;
        d = hi - lo;
        m = (k - hi) % (2 * d);
        return (m <= d) ? hi - m : lo + (m - d);
    endfunction

    function automatic int ref_ud(input int mode, input int lo, input int hi, input int k);
        if (mode == 0) return 1;
        if (mode == 1) return 0;
        return (ref_val(mode, lo, hi, k + 1) > ref_val(mode, lo, hi, k)) ? 1 : 0;
    endfunction

    task automatic accept_cmd(input int mode, input int lo, input int hi, input int p);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("ready_wait", {31'd0, bus.cmd_ready}, 1);
        bus.cmd_mode   = 2'(mode);
        bus.cmd_lo     = 3'(lo);
        bus.cmd_hi     = 3'(hi);
        bus.cmd_passes = 4'(p);
        bus.cmd_valid  = 1'b1;
        step();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic run_cmd(input int mode, input int lo, input int hi, input int p, input int abort_at);
        int len;
        accept_cmd(mode, lo, hi, p);
        if (mode == 3) begin
            check("clear_done", {31'd0, done}, 1);
            check("clear_cnt_rst", {31'd0, cnt_rst}, 1);
            check("clear_ready", {31'd0, bus.cmd_ready}, 0);
            step();
            check("clear_done_off", {31'd0, done}, 0);
            return;
        end
        if (mode == 2 && lo >= hi) begin
            check("illegal_err", {31'd0, err}, 1);
            check("illegal_busy", {31'd0, busy}, 0);
            check("illegal_cnt_rst", {31'd0, cnt_rst}, 1);
            check("illegal_ready", {31'd0, bus.cmd_ready}, 1);
            step();
            check("illegal_err_off", {31'd0, err}, 0);
            return;
        end
        len = ref_len(mode, lo, hi, p);
        for (int k = 0; k <= len; k++) begin
            check("run_count", {29'd0, cnt_count}, ref_val(mode, lo, hi, k));
            check("run_up_down", {31'd0, cnt_up_down}, ref_ud(mode, lo, hi, k));
            if (k == abort_at) begin
                bus.cmd_abort = 1'b1;
                #1;
                check("abort_cnt_rst", {31'd0, cnt_rst}, 1);
                step();
                bus.cmd_abort = 1'b0;
                check("abort_err", {31'd0, err}, 1);
                check("abort_no_done", {31'd0, done}, 0);
                check("abort_busy", {31'd0, busy}, 0);
                check("abort_count", {29'd0, cnt_count}, 0);
                step();
                check("abort_err_off", {31'd0, err}, 0);
                return;
            end
            check("run_cnt_rst", {31'd0, cnt_rst}, (k == len) ? 1 : 0);
            check("run_no_done", {31'd0, done}, 0);
            step();
        end
        check("done_pulse", {31'd0, done}, 1);
        check("done_count", {29'd0, cnt_count}, 0);
        check("done_err", {31'd0, err}, 0);
        step();
        check("done_off", {31'd0, done}, 0);
        check("idle_ready", {31'd0, bus.cmd_ready}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, lo, hi, p, ab;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_abort  = 1'b0;
        bus.cmd_mode   = '0;
        bus.cmd_lo     = '0;
        bus.cmd_hi     = '0;
        bus.cmd_passes = '0;
        step();
        step();
        check("rst_ready", {31'd0, bus.cmd_ready}, 0);
        check("rst_cnt_rst", {31'd0, cnt_rst}, 1);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, bus.cmd_ready}, 1);
        check("post_rst_count", {29'd0, cnt_count}, 0);

        run_cmd(0, 0, 5, 1, -1);
        run_cmd(1, 5, 0, 2, -1);
        run_cmd(2, 2, 5, 3, -1);
        run_cmd(2, 4, 4, 1, -1);
        run_cmd(0, 0, 6, 1, 3);
        run_cmd(3, 0, 0, 0, -1);
        run_cmd(0, 0, 0, 0, -1);

        // Reset in the middle of a run
        accept_cmd(0, 0, 6, 1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, bus.cmd_ready}, 0);
        check("midrst_cnt_rst", {31'd0, cnt_rst}, 1);
        check("midrst_up_down", {31'd0, cnt_up_down}, 1);
        step();
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_err", {31'd0, err}, 0);
        check("midrst_count", {29'd0, cnt_count}, 0);
        run_cmd(0, 0, 3, 2, -1);

`ifdef CNT_SEQ_TRACK_CHECK_EN
        accept_cmd(0, 0, 6, 1);
        step();
        step();
        step();
        check("track_count", {29'd0, cnt_count}, 3);
        glitch_val = 3'd6;
        glitch_en  = 1'b1;
        #1;
        check("track_cnt_rst", {31'd0, cnt_rst}, 1);
        step();
        glitch_en = 1'b0;
        check("track_err", {31'd0, err}, 1);
        check("track_busy", {31'd0, busy}, 0);
        check("track_no_done", {31'd0, done}, 0);
        step();
        check("track_err_off", {31'd0, err}, 0);
`endif

        for (int i = 0; i < 25; i++) begin
            mode = int'($urandom_range(0, 3));
            lo   = int'($urandom_range(0, 7));
            hi   = int'($urandom_range(0, 7));
            p    = int'($urandom_range(0, 3));
            ab   = -1;
            if (mode != 3 && !(mode == 2 && lo >= hi) && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(0, ref_len(mode, lo, hi, p)));
            run_cmd(mode, lo, hi, p, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_counter_sequencer.md
Name: updown_counter_sequencer

Overview:
- Controller that sequences the team's 3-bit up/down counter (ports clk, rst, up_down, count).
- Accepts one command at a time over a valid/ready handshake and drives the counter's rst and up_down lines: up-to-target, down-to-target, bounce between two bounds for N passes, or clear.
- Monitors the counter's count output and reports completion or error.
- Counter contract: synchronous clear to 0 when its rst=1; otherwise steps +1 (up_down=1) or -1 (up_down=0) modulo 2^WIDTH on every clk edge.

Parameters:
WIDTH, 3, counter width; bounds and count are WIDTH bits.
PASS_W, 4, width of pass-count field and internal pass counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_mode  in  2  00 UP, 01 DOWN, 10 BOUNCE, 11 CLEAR
cmd_lo  in  WIDTH  lower bound / DOWN target
cmd_hi  in  WIDTH  upper bound / UP target
cmd_passes  in  PASS_W  bound arrivals before completion; 0 treated as 1
cmd_abort  in  1  abort current command
cnt_count  in  WIDTH  counter's count output
cnt_rst  out  1  drives counter rst
cnt_up_down  out  1  drives counter up_down
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at edge) -> IDLE; pass counter 0; done=0, err=0; dir register 1.
- While rst=1: cmd_ready=0, cnt_rst=1, cnt_up_down=1.
- IDLE:
  - cmd_ready=1, cnt_rst=1 (counter parked at 0), cnt_up_down=1.
  - On cmd_valid&cmd_ready: latch mode/lo/hi/passes.
  - CLEAR -> DONE.
  - BOUNCE with lo>=hi -> err pulse next cycle, stay IDLE.
  - Otherwise -> RUN.
- RUN:
  - cmd_ready=0. First RUN cycle sees cnt_count=0; the "stepped" flag is clear in that cycle.
  - cnt_up_down is combinational, with zero lag:
    - UP: 1.
    - DOWN: 0.
    - BOUNCE: 0 if cnt_count==hi; else 1 if cnt_count==lo; else dir register. Dir register loads cnt_up_down each RUN cycle.
  - Arrival, counted only when stepped=1:
    - UP: cnt_count==hi.
    - DOWN: cnt_count==lo.
    - BOUNCE: cnt_count==hi, or cnt_count==lo after hi has been reached once.
  - Each arrival increments the pass counter.
  - Final arrival (pass counter == effective passes-1): cnt_rst=1 combinationally in that cycle; -> DONE.
  - Otherwise cnt_rst=0.
  - cmd_abort=1 in RUN: cnt_rst=1 that cycle; -> IDLE; err pulse next cycle. Abort takes priority over a simultaneous final arrival.
  - cmd_abort is ignored outside RUN.
- DONE: done=1 for exactly one cycle, cnt_rst=1, cmd_ready=0; -> IDLE.
- Timing, with acceptance in cycle t:
  - UP: RUN cycles t+1..t+1+hi+8(P-1); done in cycle t+2+hi+8(P-1). hi=0 requires 8 steps per pass.
  - DOWN: steps per pass = (8-lo) mod 8, 0 meaning 8.
  - CLEAR: done in cycle t+1.
- Wrap-around: the counter wraps modulo 8; the sequencer never treats a wrap as an arrival unless the value matches the target.
- Back-to-back commands: the earliest next accept is the IDLE cycle after DONE. The counter is always 0 at every RUN entry.
- Reset mid-RUN: -> IDLE immediately; no done/err pulse; pass counter cleared.

Optional Feature:
CNT_SEQ_TRACK_CHECK_EN:
- Defined: the sequencer keeps an expected-count register (0 at RUN entry, stepped per cnt_up_down each RUN cycle). Any RUN-cycle mismatch of cnt_count vs expected: cnt_rst=1, -> IDLE, err pulse next cycle, no done.
- Undefined: no tracking logic; err only for illegal BOUNCE or abort.

Test Plan:
- Reset: hold rst 2 cycles -> cmd_ready=0, cnt_rst=1, done=0, err=0; after release cmd_ready=1, cnt_count=0.
- UP hi=5 passes=1, accepted cycle t -> cnt_up_down=1, count 0..5 over t+1..t+6, cnt_rst=1 at t+6, done=1 only at t+7, count=0 at t+7.
- DOWN lo=5 passes=2 -> count 0,7,6,5,4,3,2,1,0,7,6,5; done one cycle after second 5; cnt_up_down=0 throughout.
- BOUNCE lo=2 hi=5 passes=3 -> count 0,1,2,3,4,5,4,3,2,3,4,5; done at t+13; cnt_up_down drops in the cycle count==5 and rises at count==2.
- Errors: BOUNCE lo=4 hi=4 -> err one cycle, stays IDLE, cnt_rst=1. UP hi=6, cmd_abort at count=3 -> err next cycle, no done, count=0.
- CLEAR, then UP hi=0 passes=0 issued immediately -> CLEAR done at t+1; UP accepted at t+2; 8 steps; done after count returns to 0. With CNT_SEQ_TRACK_CHECK_EN, forcing cnt_count=6 while 3 is expected -> err, IDLE.
